// File: rtl/ctrl_pila_pkg.sv
// Shared definitions for the return-address stack controller:
// FSM states, PC-source select codes and interrupt-line count.
package ctrl_pila_pkg;

  localparam int ANCHO_DEF = 10;
  localparam int N_INT     = 4;
  localparam int IDX_W     = $clog2(N_INT);

  typedef enum logic {
    REPOSO = 1'b0,
    EN_ISR = 1'b1
  } estado_t;

  typedef enum logic [1:0] {
    PC_SEC  = 2'b00,
    PC_PILA = 2'b01,
    PC_VEC  = 2'b10
  } pc_sel_t;

  // One-hot mask selecting a single interrupt line.
  function automatic logic [N_INT-1:0] one_hot(input logic [IDX_W-1:0] idx);
    return N_INT'(1) << idx;
  endfunction

endpackage

// File: rtl/prioridad_int.sv
// Interrupt request front end: registers the request lines once, latches
// a pending bit on every 0->1 transition and reports the lowest-index
// pending line. A pending bit persists until the controller clears it
// through borra.
module prioridad_int
  import ctrl_pila_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_INT-1:0] int_req,
  input  logic [N_INT-1:0] borra,
  output logic [N_INT-1:0] pend,
  output logic             valido,
  output logic [IDX_W-1:0] indice
);

  logic [N_INT-1:0] req_q;
  logic [N_INT-1:0] sube;

  assign sube = int_req & ~req_q;

  // Request history and pending bits; a new edge wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      req_q <= '0;
      pend  <= '0;
    end else begin
      req_q <= int_req;
      pend  <= (pend & ~borra) | sube;
    end
  end

  // Lowest-index pending line has priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    indice = '0;
    valido = |pend;
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (pend[i]) indice = IDX_W'(i);
    end
  end

endmodule

// File: rtl/ctrl_pila_int.sv
// Return-address stack initiator: turns call/ret/reti strobes and the
// interrupt lines into single-cycle push/pop/weSP commands, chooses the
// next-PC source and tracks interrupt enable and in-service state.
// Optional feature macro: CTRL_PILA_LIMITES_EN (depth counter, overflow /
// underflow suppression and sticky desborde/subdesborde flags).
module ctrl_pila_int
  import ctrl_pila_pkg::*;
#(
  parameter int               ANCHO    = ANCHO_DEF,
  parameter int               PROF_MAX = 16,
  parameter logic [ANCHO-1:0] VEC_BASE = ANCHO'(10'h3C0)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             call,
  input  logic             ret,
  input  logic             reti,
  input  logic             ei,
  input  logic             di,
  input  logic [3:0]       int_req,
  input  logic [ANCHO-1:0] pc_actual,
  input  logic [ANCHO-1:0] pc_mas1,
  output logic             weSP,
  output logic             push,
  output logic             pop,
  output logic [ANCHO-1:0] entrada_pila,
  output logic [1:0]       pc_sel,
  output logic [ANCHO-1:0] pc_vector,
  output logic             anula,
  output logic             en_isr,
  output logic             desborde,
  output logic             subdesborde
);

  estado_t          estado, estado_sig;
  logic             ie_q;
  logic [N_INT-1:0] pend;
  logic [N_INT-1:0] borra;
  logic             valido;
  logic [IDX_W-1:0] indice;
  logic             acepta;
  logic             push_req, pop_req;
  logic             ovf, udf;
  pc_sel_t          sel;

  prioridad_int u_prioridad (
    .clk     (clk),
    .reset   (reset),
    .int_req (int_req),
    .borra   (borra),
    .pend    (pend),
    .valido  (valido),
    .indice  (indice)
  );

`ifdef CTRL_PILA_LIMITES_EN
  localparam int PW = $clog2(PROF_MAX + 1);

  logic [PW-1:0] prof_q;
  logic          desb_q, subd_q;
  logic          lleno, vacio;

  assign lleno = (prof_q == PW'(PROF_MAX));
  assign vacio = (prof_q == '0);

  // Depth counter follows the commands actually issued; flags are sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      prof_q <= '0;
      desb_q <= 1'b0;
      subd_q <= 1'b0;
    end else begin
      if (push)     prof_q <= prof_q + PW'(1);
      else if (pop) prof_q <= prof_q - PW'(1);
      if (ovf) desb_q <= 1'b1;
      if (udf) subd_q <= 1'b1;
    end
  end

  // The flags show up in the same cycle as the offending command.
  assign desborde    = ~reset & (desb_q | ovf);
  assign subdesborde = ~reset & (subd_q | udf);
`else
  logic lleno, vacio;

  assign lleno       = 1'b0;
  assign vacio       = 1'b0;
  assign desborde    = 1'b0;
  assign subdesborde = 1'b0;
`endif

  // State register and interrupt enable; an accepted interrupt discards
  // any ei/di of the instruction it replaces.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= REPOSO;
      ie_q   <= 1'b0;
    end else begin
      estado <= estado_sig;
      if (!acepta) begin
        if (di)      ie_q <= 1'b0;
        else if (ei) ie_q <= 1'b1;
      end
    end
  end

  // Command decode: interrupt accept, then call, then ret/reti; then the
  // depth limits veto commands the stack cannot honour.
  always_comb begin
    estado_sig   = estado;
    acepta       = 1'b0;
    borra        = '0;
    push_req     = 1'b0;
    pop_req      = 1'b0;
    entrada_pila = '0;
    sel          = PC_SEC;
    pc_vector    = '0;
    anula        = 1'b0;
    ovf          = 1'b0;
    udf          = 1'b0;

    if (!reset) begin
      if (estado == REPOSO && ie_q && valido) begin
        acepta       = 1'b1;
        borra        = one_hot(indice);
        push_req     = 1'b1;
        entrada_pila = pc_actual;
        anula        = 1'b1;
        sel          = PC_VEC;
        pc_vector    = VEC_BASE + ANCHO'({indice, 2'b00});
        estado_sig   = EN_ISR;
      end else if (call) begin
        push_req     = 1'b1;
        entrada_pila = pc_mas1;
      end else if (ret || reti) begin
        pop_req = 1'b1;
        sel     = PC_PILA;
        if (reti && estado == EN_ISR) estado_sig = REPOSO;
      end

      if (push_req && lleno) begin
        ovf   = 1'b1;
        anula = 1'b1;
        if (acepta) estado_sig = REPOSO;
      end
      if (pop_req && vacio) begin
        udf = 1'b1;
        sel = PC_SEC;
      end
    end

    push = push_req & ~ovf;
    pop  = pop_req & ~udf;
    weSP = push | pop;
  end

  assign pc_sel = sel;
  assign en_isr = ~reset & (estado == EN_ISR);

endmodule

// File: tb/tb_ctrl_pila_int.sv
// Self-checking bench for ctrl_pila_int: a behavioural model (shadow stack
// queue, pending bits, enable and in-service flags) is compared against the
// DUT every cycle, and directed scenarios add hand-computed expectations.
module tb_ctrl_pila_int;

`ifdef CTRL_PILA_LIMITES_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif
  localparam int PROF = 16;

  logic       clk = 1'b0;
  logic       reset, call, ret, reti, ei, di;
  logic [3:0] int_req;
  logic [9:0] pc_actual, pc_mas1;
  logic       weSP, push, pop, anula, en_isr, desborde, subdesborde;
  logic [9:0] entrada_pila, pc_vector;
  logic [1:0] pc_sel;

  int errors = 0;
  int checks = 0;

  // stimulus holding values, applied just after each rising edge
  logic       rst_v = 1'b1;
  logic [3:0] req_v = 4'b0;
  logic [9:0] pa_v  = 10'h0;

  always #5 clk = ~clk;

  ctrl_pila_int dut (
    .clk          (clk),
    .reset        (reset),
    .call         (call),
    .ret          (ret),
    .reti         (reti),
    .ei           (ei),
    .di           (di),
    .int_req      (int_req),
    .pc_actual    (pc_actual),
    .pc_mas1      (pc_mas1),
    .weSP         (weSP),
    .push         (push),
    .pop          (pop),
    .entrada_pila (entrada_pila),
    .pc_sel       (pc_sel),
    .pc_vector    (pc_vector),
    .anula        (anula),
    .en_isr       (en_isr),
    .desborde     (desborde),
    .subdesborde  (subdesborde)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [9:0] m_stk[$];
  bit         m_ie, m_isr, m_desb, m_sub;
  bit [3:0]   m_pend, m_prev;

  initial begin
    m_ie = 0; m_isr = 0; m_desb = 0; m_sub = 0; m_pend = 0; m_prev = 0;
    forever begin
      bit       e_push, e_pop, e_anula, acc, want_push, want_pop, do_push, do_pop, clr;
      bit       ev_o, ev_u, n_ie, n_isr, n_desb, n_sub;
      bit [3:0] n_pend, n_prev;
      bit [9:0] word, e_vec;
      bit [1:0] e_sel;
      int       k;

      @(negedge clk);
      e_push = 0; e_pop = 0; e_anula = 0; e_sel = 0; e_vec = 0; word = 0;
      acc = 0; want_push = 0; want_pop = 0; do_push = 0; do_pop = 0; clr = 0;
      ev_o = 0; ev_u = 0;
      n_ie = m_ie; n_isr = m_isr; n_pend = m_pend; n_prev = m_prev;
      n_desb = m_desb; n_sub = m_sub;

      if (reset) begin
        clr = 1; n_ie = 0; n_isr = 0; n_pend = 0; n_prev = 0; n_desb = 0; n_sub = 0;
      end else begin
        k = -1;
        for (int i = 0; i < 4; i++) if (m_pend[i] && k < 0) k = i;
        acc = m_ie && !m_isr && (k >= 0);
        if (acc) begin
          want_push = 1; word = pc_actual; e_anula = 1; e_sel = 2;
          e_vec = 10'h3C0 + 10'(4 * k);
          n_pend[k] = 0; n_isr = 1;
        end else if (call) begin
          want_push = 1; word = pc_mas1;
        end else if (ret || reti) begin
          want_pop = 1; e_sel = 1;
          if (reti && m_isr) n_isr = 0;
        end
        if (want_push) begin
          if (LIM && m_stk.size() >= PROF) begin
            e_anula = 1; ev_o = 1;
            if (acc) n_isr = m_isr;
          end else begin
            e_push = 1; do_push = 1;
          end
        end
        if (want_pop) begin
          if (LIM && m_stk.size() == 0) begin
            e_sel = 0; ev_u = 1;
          end else begin
            e_pop = 1; do_pop = 1;
          end
        end
        if (!acc) begin
          if (di)      n_ie = 0;
          else if (ei) n_ie = 1;
        end
        n_pend = n_pend | (int_req & ~m_prev);
        n_prev = int_req;
        if (LIM) begin
          n_desb = m_desb | ev_o;
          n_sub  = m_sub | ev_u;
        end
      end

      check("push", push, e_push);
      check("pop", pop, e_pop);
      check("weSP", weSP, e_push | e_pop);
      check("entrada_pila", entrada_pila, word);
      check("pc_sel", pc_sel, e_sel);
      check("pc_vector", pc_vector, e_vec);
      check("anula", anula, e_anula);
      check("en_isr", en_isr, reset ? 1'b0 : m_isr);
      check("desborde", desborde, reset ? 1'b0 : n_desb);
      check("subdesborde", subdesborde, reset ? 1'b0 : n_sub);

      @(posedge clk);
      if (clr) m_stk.delete();
      if (do_push) m_stk.push_back(word);
      if (do_pop && m_stk.size() > 0) void'(m_stk.pop_back());
      m_ie = n_ie; m_isr = n_isr; m_pend = n_pend; m_prev = n_prev;
      m_desb = n_desb; m_sub = n_sub;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic apply(input bit c, input bit r, input bit ri, input bit e, input bit d);
    @(posedge clk);
    #1;
    reset = rst_v; call = c; ret = r; reti = ri; ei = e; di = d;
    int_req = req_v; pc_actual = pa_v; pc_mas1 = pa_v + 10'd1;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; call = 0; ret = 0; reti = 0; ei = 0; di = 0;
    int_req = 0; pc_actual = 0; pc_mas1 = 1;

    // reset state
    idle();
    idle();
    check("reset_push", push, 0);
    check("reset_en_isr", en_isr, 0);
    check("reset_pc_sel", pc_sel, 0);
    rst_v = 0;
    idle();
    check("post_reset_weSP", weSP, 0);

    // call then ret
    pa_v = 10'h010;
    apply(1, 0, 0, 0, 0);
    check("call_push", push, 1);
    check("call_weSP", weSP, 1);
    check("call_entrada", entrada_pila, 10'h011);
    apply(0, 1, 0, 0, 0);
    check("ret_pop", pop, 1);
    check("ret_pc_sel", pc_sel, 2'b01);
    idle();

    // single interrupt on line 2
    apply(0, 0, 0, 1, 0);
    req_v = 4'b0100; pa_v = 10'h050;
    idle();
    check("irq2_not_yet", push, 0);
    idle();
    check("irq2_push", push, 1);
    check("irq2_entrada", entrada_pila, 10'h050);
    check("irq2_vector", pc_vector, 10'h3C8);
    check("irq2_anula", anula, 1);
    check("irq2_pc_sel", pc_sel, 2'b10);
    idle();
    check("irq2_en_isr", en_isr, 1);
    apply(0, 0, 1, 0, 0);
    check("reti2_pop", pop, 1);
    check("reti2_pc_sel", pc_sel, 2'b01);
    idle();
    check("reti2_en_isr", en_isr, 0);

    // lines 0 and 3 together: 0 first, 3 right after reti
    req_v = 4'b1101;
    idle();
    idle();
    check("irq0_vector", pc_vector, 10'h3C0);
    idle();
    apply(0, 0, 1, 0, 0);
    idle();
    check("irq3_push", push, 1);
    check("irq3_vector", pc_vector, 10'h3CC);
    apply(0, 0, 1, 0, 0);
    idle();

    // accept coincident with call: call discarded
    req_v = 4'b1111; pa_v = 10'h070;
    idle();
    apply(1, 0, 0, 0, 0);
    check("irqcall_entrada", entrada_pila, 10'h070);
    check("irqcall_vector", pc_vector, 10'h3C4);
    check("irqcall_anula", anula, 1);
    apply(0, 0, 1, 0, 0);
    idle();

    // ei+di together leaves interrupts disabled; pend persists
    apply(0, 0, 0, 1, 1);
    req_v = 4'b0000;
    idle();
    req_v = 4'b0100;
    idle();
    idle();
    check("masked_push", push, 0);
    apply(0, 0, 0, 1, 0);
    idle();
    check("unmasked_vector", pc_vector, 10'h3C8);
    apply(0, 0, 1, 0, 0);
    req_v = 4'b0000;
    idle();

    // depth limits: 17 calls then 17 rets
    apply(0, 0, 0, 0, 1);
    pa_v = 10'h100;
    for (int i = 0; i < PROF; i++) apply(1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0);
`ifdef CTRL_PILA_LIMITES_EN
    check("ovf_push", push, 0);
    check("ovf_desborde", desborde, 1);
    check("ovf_anula", anula, 1);
`else
    check("nolim_push17", push, 1);
    check("nolim_desborde", desborde, 0);
`endif
    for (int i = 0; i < PROF; i++) apply(0, 1, 0, 0, 0);
    apply(0, 1, 0, 0, 0);
`ifdef CTRL_PILA_LIMITES_EN
    check("udf_pop", pop, 0);
    check("udf_subdesborde", subdesborde, 1);
    check("udf_pc_sel", pc_sel, 2'b00);
`else
    check("nolim_pop17", pop, 1);
    check("nolim_subdesborde", subdesborde, 0);
`endif
    idle();

    // reset in service clears en_isr, pend and ie
    apply(0, 0, 0, 1, 0);
    req_v = 4'b0001;
    idle();
    idle();
    check("rst_isr_enter", push, 1);
    req_v = 4'b0011;
    idle();
    check("rst_isr_active", en_isr, 1);
    rst_v = 1; req_v = 4'b0000;
    idle();
    rst_v = 0;
    idle();
    check("rst_isr_en_isr", en_isr, 0);
    req_v = 4'b1000;
    idle();
    idle();
    check("rst_ie_cleared", push, 0);
    apply(0, 0, 0, 1, 0);
    idle();
    check("rst_pend_cleared_vector", pc_vector, 10'h3CC);
    apply(0, 0, 1, 0, 0);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
